// File: rtl/rx_reset_sequencer_pkg.sv
// Shared encodings and default widths for the receiver reset sequencer and its status registers.
// The state values are visible to software, so they must stay fixed.
package rx_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_HOLDOFF = 2'd2,
    S_LOCKOUT = 2'd3
  } rx_state_e;

  localparam int RST_LEN_WIDTH_DEF = 8;
  localparam int HOLDOFF_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF     = 16;
  localparam int STORM_TH_WIDTH    = 8;

endpackage

// File: rtl/rx_reset_sequencer_storm_detector.sv
// Trip-storm window tracker: storm_hit is combinational on the current trip, state updates next edge.
// No backpressure; a trip is seen only in the cycle it is presented.
module storm_detector
  import rx_reset_sequencer_pkg::*;
#(
  parameter int WIN_WIDTH = HOLDOFF_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      trip_in,
  input  logic                      clear,
  input  logic [STORM_TH_WIDTH-1:0] storm_th,
  input  logic [WIN_WIDTH-1:0]      storm_window,
  output logic                      storm_hit
);

  logic [WIN_WIDTH-1:0]      win_q, win_d;
  logic [STORM_TH_WIDTH-1:0] cnt_q, cnt_d;
  logic [STORM_TH_WIDTH-1:0] cnt_next;
  logic                      active;
  logic                      in_window;

  always_comb begin
    active    = trip_in && (storm_th != '0);
    in_window = (win_q != '0);
    if (!in_window) begin
      cnt_next = STORM_TH_WIDTH'(1);
    end else if (cnt_q == '1) begin
      cnt_next = cnt_q;
    end else begin
      cnt_next = cnt_q + STORM_TH_WIDTH'(1);
    end
    storm_hit = active && (cnt_next == storm_th);

    win_d = win_q;
    cnt_d = cnt_q;
    if (clear) begin
      win_d = '0;
      cnt_d = '0;
    end else begin
      if (in_window) begin
        win_d = win_q - WIN_WIDTH'(1);
      end
      // A trip outside a live window opens a fresh one and restarts the count at 1.
      if (active) begin
        cnt_d = cnt_next;
        if (!in_window) begin
          win_d = storm_window;
        end
      end else if (win_q == WIN_WIDTH'(1)) begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_q <= '0;
      cnt_q <= '0;
    end else begin
      win_q <= win_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_reset_sequencer.sv
// Turns watchdog trips and software requests into a fixed rx_rst pulse plus watchdog blanking window.
// One-cycle request-to-rx_rst latency; requests outside IDLE/HOLDOFF are dropped, not queued.
module rx_reset_sequencer
  import rx_reset_sequencer_pkg::*;
#(
  parameter int RST_LEN_WIDTH = RST_LEN_WIDTH_DEF,
  parameter int HOLDOFF_WIDTH = HOLDOFF_WIDTH_DEF,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      enable,
  input  logic                      wd_trip,
  input  logic                      sw_rst_req,
  input  logic [RST_LEN_WIDTH-1:0]  rst_len,
  input  logic [HOLDOFF_WIDTH-1:0]  holdoff_len,
  input  logic [STORM_TH_WIDTH-1:0] storm_th,
  input  logic [HOLDOFF_WIDTH-1:0]  storm_window,
  input  logic                      cnt_clr,
  output logic                      rx_rst,
  output logic                      wd_enable,
  output logic                      busy,
  output logic                      lockout,
  output logic [CNT_WIDTH-1:0]      trip_cnt,
  output logic [1:0]                state
);

  rx_state_e               state_q, state_d;
  logic [RST_LEN_WIDTH-1:0] len_q, len_d, len_load;
  logic [HOLDOFF_WIDTH-1:0] hold_q, hold_d;
  logic [CNT_WIDTH-1:0]     trip_cnt_q, trip_cnt_d;
  logic rx_rst_q, rx_rst_d, wd_enable_q, wd_enable_d;
  logic busy_q, busy_d, lockout_q, lockout_d;
  logic trip_acc, storm_hit, storm_clr;

  storm_detector #(
    .WIN_WIDTH (HOLDOFF_WIDTH)
  ) u_storm (
    .clk          (clk),
    .rstn         (rstn),
    .trip_in      (trip_acc),
    .clear        (storm_clr),
    .storm_th     (storm_th),
    .storm_window (storm_window),
    .storm_hit    (storm_hit)
  );

  always_comb begin
    trip_acc  = (state_q == S_IDLE) && enable && wd_trip;
    len_load  = (rst_len == '0) ? RST_LEN_WIDTH'(1) : rst_len;
    state_d   = state_q;
    len_d     = len_q;
    hold_d    = hold_q;
    storm_clr = 1'b0;

    if (!enable) begin
      state_d   = S_IDLE;
      len_d     = '0;
      hold_d    = '0;
      storm_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trip_acc && storm_hit) begin
            state_d = S_LOCKOUT;
          end else if (trip_acc || sw_rst_req) begin
            state_d = S_ASSERT;
            len_d   = len_load;
          end
        end
        S_ASSERT: begin
          if (len_q <= RST_LEN_WIDTH'(1)) begin
            len_d = '0;
            if (holdoff_len != '0) begin
              state_d = S_HOLDOFF;
              hold_d  = holdoff_len;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            len_d = len_q - RST_LEN_WIDTH'(1);
          end
        end
        S_HOLDOFF: begin
          if (sw_rst_req) begin
            state_d = S_ASSERT;
            len_d   = len_load;
            hold_d  = '0;
          end else if (hold_q <= HOLDOFF_WIDTH'(1)) begin
            state_d = S_IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q - HOLDOFF_WIDTH'(1);
          end
        end
        S_LOCKOUT: begin
          if (cnt_clr) begin
            state_d   = S_IDLE;
            storm_clr = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Clear beats a same-cycle trip so software always reads a clean zero afterwards.
    if (cnt_clr) begin
      trip_cnt_d = '0;
    end else if (trip_acc && (trip_cnt_q != '1)) begin
      trip_cnt_d = trip_cnt_q + CNT_WIDTH'(1);
    end else begin
      trip_cnt_d = trip_cnt_q;
    end

    rx_rst_d    = (state_d == S_ASSERT);
    busy_d      = (state_d == S_ASSERT) || (state_d == S_HOLDOFF);
    lockout_d   = (state_d == S_LOCKOUT);
    wd_enable_d = (state_d == S_IDLE) && enable;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      hold_q      <= '0;
      trip_cnt_q  <= '0;
      rx_rst_q    <= 1'b0;
      wd_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      hold_q      <= hold_d;
      trip_cnt_q  <= trip_cnt_d;
      rx_rst_q    <= rx_rst_d;
      wd_enable_q <= wd_enable_d;
      busy_q      <= busy_d;
      lockout_q   <= lockout_d;
    end
  end

  assign rx_rst    = rx_rst_q;
  assign wd_enable = wd_enable_q;
  assign busy      = busy_q;
  assign lockout   = lockout_q;
  assign trip_cnt  = trip_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_rx_reset_sequencer.sv
// Bench for rx_reset_sequencer: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized segments.
module tb_rx_reset_sequencer;

  localparam int RLW  = 8;
  localparam int HW   = 16;
  localparam int CW   = 10;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0, rstn = 1'b0;
  logic enable = 1'b0, wd_trip = 1'b0, sw_rst_req = 1'b0, cnt_clr = 1'b0;
  logic [RLW-1:0] rst_len = '0;
  logic [HW-1:0]  holdoff_len = '0, storm_window = '0;
  logic [7:0]     storm_th = '0;
  logic rx_rst, wd_enable, busy, lockout;
  logic [CW-1:0] trip_cnt;
  logic [1:0]    state;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  rx_reset_sequencer #(.RST_LEN_WIDTH(RLW), .HOLDOFF_WIDTH(HW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .wd_trip(wd_trip), .sw_rst_req(sw_rst_req),
    .rst_len(rst_len), .holdoff_len(holdoff_len), .storm_th(storm_th),
    .storm_window(storm_window), .cnt_clr(cnt_clr), .rx_rst(rx_rst), .wd_enable(wd_enable),
    .busy(busy), .lockout(lockout), .trip_cnt(trip_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phases end at absolute cycle stamps; the storm window is a stamp too.
  int m_state, m_end, m_win_end, m_storm_n, m_cnt, cyc, m_nxt;
  bit m_wden, m_acc, m_lock, m_in;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_state = 0; m_end = 0; m_win_end = -1; m_storm_n = 0; m_cnt = 0; m_wden = 0; cyc = 0;
    end else begin
      m_acc = (m_state == 0) && enable && wd_trip;
      m_nxt = m_state;
      if (!enable) begin
        m_nxt = 0; m_win_end = -1; m_storm_n = 0;
      end else if (m_state == 0) begin
        m_lock = 0;
        if (m_acc && storm_th != 0) begin
          m_in = (m_win_end >= cyc);
          m_storm_n = m_in ? m_storm_n + 1 : 1;
          if (!m_in) m_win_end = cyc + int'(storm_window);
          m_lock = (m_storm_n == int'(storm_th));
        end
        if (m_lock) m_nxt = 3;
        else if (m_acc || sw_rst_req) begin
          m_nxt = 1; m_end = cyc + ((rst_len == 0) ? 1 : int'(rst_len));
        end
      end else if (m_state == 1) begin
        if (cyc == m_end) begin
          if (holdoff_len != 0) begin m_nxt = 2; m_end = cyc + int'(holdoff_len); end
          else m_nxt = 0;
        end
      end else if (m_state == 2) begin
        if (sw_rst_req) begin m_nxt = 1; m_end = cyc + ((rst_len == 0) ? 1 : int'(rst_len)); end
        else if (cyc == m_end) m_nxt = 0;
      end else if (cnt_clr) begin
        m_nxt = 0; m_win_end = -1; m_storm_n = 0;
      end
      if (cnt_clr) m_cnt = 0;
      else if (m_acc && m_cnt < CMAX) m_cnt++;
      m_state = m_nxt;
      m_wden  = (m_nxt == 0) && enable;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_state", state, m_state);
      cmp("model_rx_rst", rx_rst, m_state == 1);
      cmp("model_busy", busy, (m_state == 1) || (m_state == 2));
      cmp("model_lockout", lockout, m_state == 3);
      cmp("model_wd_enable", wd_enable, m_wden);
      cmp("model_trip_cnt", trip_cnt, m_cnt);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1 rstn = 1'b0;
    wd_trip = 0; sw_rst_req = 0; cnt_clr = 0; enable = 0;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  int rises;
  logic prev;
  bit saw;

  initial begin
    chk_en = 1'b1;
    @(negedge clk);
    cmp("rst_rx_rst", rx_rst, 0);
    cmp("rst_wd_enable", wd_enable, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_lockout", lockout, 0);
    cmp("rst_trip_cnt", trip_cnt, 0);
    cmp("rst_state", state, 0);

    // Basic trip
    do_reset();
    rst_len = 4; holdoff_len = 10; storm_th = 0; storm_window = 0; enable = 1;
    @(negedge clk);
    wd_trip = 1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      wd_trip = 0;
      cmp("basic_rx_rst", rx_rst, (k <= 4));
      cmp("basic_busy", busy, (k <= 14));
      cmp("basic_wd_enable", wd_enable, (k > 14));
      cmp("basic_state", state, (k <= 4) ? 1 : (k <= 14) ? 2 : 0);
    end
    cmp("basic_trip_cnt", trip_cnt, 1);

    // Blanking: trip held high for 20 cycles
    do_reset();
    rst_len = 4; holdoff_len = 10; enable = 1;
    @(negedge clk);
    wd_trip = 1; rises = 0; prev = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 20) wd_trip = 0;
      if (k <= 15 && rx_rst && !prev) rises++;
      prev = rx_rst;
      if (k == 16) begin
        cmp("blank_state16", state, 1);
        cmp("blank_trip_cnt", trip_cnt, 2);
      end
    end
    cmp("blank_single_pulse", rises, 1);
    repeat (12) @(negedge clk);

    // Zero lengths
    do_reset();
    rst_len = 0; holdoff_len = 0; enable = 1;
    @(negedge clk);
    wd_trip = 1;
    @(negedge clk);
    wd_trip = 0;
    cmp("zero_rx_rst1", rx_rst, 1);
    cmp("zero_busy1", busy, 1);
    @(negedge clk);
    cmp("zero_rx_rst2", rx_rst, 0);
    cmp("zero_busy2", busy, 0);
    cmp("zero_state2", state, 0);

    // Storm lockout
    do_reset();
    storm_th = 3; storm_window = 100; rst_len = 2; holdoff_len = 5; enable = 1;
    @(negedge clk);
    rises = 0; prev = 0;
    for (int c = 0; c <= 40; c++) begin
      wd_trip = (c == 0 || c == 20 || c == 40);
      @(negedge clk);
      if (rx_rst && !prev) rises++;
      prev = rx_rst;
    end
    wd_trip = 0;
    cmp("storm_state", state, 3);
    cmp("storm_lockout", lockout, 1);
    cmp("storm_rx_rst", rx_rst, 0);
    cmp("storm_trip_cnt", trip_cnt, 3);
    cmp("storm_resets", rises, 2);
    repeat (3) @(negedge clk);
    sw_rst_req = 1;
    @(negedge clk);
    sw_rst_req = 0;
    cmp("lock_ignores_sw", state, 3);
    cnt_clr = 1;
    @(negedge clk);
    cnt_clr = 0;
    cmp("unlock_state", state, 0);
    cmp("unlock_trip_cnt", trip_cnt, 0);
    cmp("unlock_lockout", lockout, 0);

    // Widely spaced trips never lock out
    do_reset();
    storm_th = 3; storm_window = 100; rst_len = 2; holdoff_len = 5; enable = 1;
    @(negedge clk);
    saw = 0;
    for (int c = 0; c <= 310; c++) begin
      wd_trip = (c % 150 == 0);
      @(negedge clk);
      if (lockout) saw = 1;
    end
    wd_trip = 0;
    cmp("spaced_no_lockout", saw, 0);
    cmp("spaced_trip_cnt", trip_cnt, 3);

    // sw_rst_req in HOLDOFF, enable abort, async reset mid-ASSERT
    do_reset();
    storm_th = 0; rst_len = 4; holdoff_len = 10; enable = 1;
    @(negedge clk);
    for (int c = 0; c <= 7; c++) begin
      wd_trip = (c == 0);
      sw_rst_req = (c == 7);
      @(negedge clk);
    end
    sw_rst_req = 0;
    cmp("swreq_state", state, 1);
    cmp("swreq_rx_rst", rx_rst, 1);
    cmp("swreq_trip_cnt", trip_cnt, 1);
    @(negedge clk);
    enable = 0;
    @(negedge clk);
    enable = 1;
    cmp("abort_state", state, 0);
    cmp("abort_rx_rst", rx_rst, 0);
    cmp("abort_trip_cnt", trip_cnt, 1);
    repeat (2) @(negedge clk);
    wd_trip = 1;
    @(negedge clk);
    wd_trip = 0;
    @(negedge clk);
    cmp("pre_arst_rx_rst", rx_rst, 1);
    #2 rstn = 0;
    #1;
    cmp("arst_rx_rst", rx_rst, 0);
    cmp("arst_state", state, 0);
    @(negedge clk);
    #1 rstn = 1;

    // Saturation and clear-vs-trip
    do_reset();
    storm_th = 0; rst_len = 0; holdoff_len = 0; enable = 1;
    @(negedge clk);
    wd_trip = 1;
    repeat (2 * CMAX + 60) @(negedge clk);
    cmp("sat_trip_cnt", trip_cnt, CMAX);
    repeat (4) @(negedge clk);
    cmp("sat_hold", trip_cnt, CMAX);
    wd_trip = 0;
    repeat (3) @(negedge clk);
    wd_trip = 1; cnt_clr = 1;
    @(negedge clk);
    wd_trip = 0; cnt_clr = 0;
    cmp("clr_vs_trip", trip_cnt, 0);
    cmp("clr_vs_trip_state", state, 1);

    // Randomized segments
    for (int s = 0; s < 6; s++) begin
      do_reset();
      rst_len      = RLW'($urandom_range(0, 5));
      holdoff_len  = HW'($urandom_range(0, 8));
      storm_th     = 8'($urandom_range(0, 4));
      storm_window = HW'($urandom_range(0, 60));
      enable = 1;
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        wd_trip    = ($urandom_range(0, 99) < 30);
        sw_rst_req = ($urandom_range(0, 99) < 5);
        enable     = ($urandom_range(0, 99) >= 3);
        cnt_clr    = ($urandom_range(0, 99) < 3);
        if ($urandom_range(0, 99) < 5) rst_len = RLW'($urandom_range(0, 5));
        if ($urandom_range(0, 99) < 5) holdoff_len = HW'($urandom_range(0, 8));
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_reset_sequencer.md
Name: rx_reset_sequencer

Overview:
Controller that sits between the signal watchdog and the OFDM receiver chain. It turns raw watchdog trip indications and software reset requests into a clean, fixed-length receiver reset pulse, then a blanking (holdoff) window during which the watchdog is gated off. It also detects trip storms, latching a lockout that stops further resets until software intervenes, and keeps a saturating trip counter for status registers.

Parameters:
RST_LEN_WIDTH, 8, width of rst_len input
HOLDOFF_WIDTH, 16, width of holdoff_len and storm_window inputs
CNT_WIDTH, 16, width of trip_cnt output

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
enable  in  1  block enable; low forces IDLE
wd_trip  in  1  trip level/pulse from the signal watchdog
sw_rst_req  in  1  single-cycle software reset request
rst_len  in  RST_LEN_WIDTH  rx_rst assertion length in cycles; 0 treated as 1
holdoff_len  in  HOLDOFF_WIDTH  blanking cycles after reset; 0 means no holdoff
storm_th  in  8  trips per window that trigger lockout; 0 disables storm detection
storm_window  in  HOLDOFF_WIDTH  storm observation window in cycles
cnt_clr  in  1  clears trip_cnt and releases lockout
rx_rst  out  1  receiver reset, active high
wd_enable  out  1  enable for the watchdog
busy  out  1  high in ASSERT or HOLDOFF
lockout  out  1  high in LOCKOUT
trip_cnt  out  CNT_WIDTH  saturating count of accepted watchdog trips
state  out  2  0=IDLE 1=ASSERT 2=HOLDOFF 3=LOCKOUT

Behaviour:
- All outputs are registered. Reset values: rx_rst=0, wd_enable=0, busy=0, lockout=0, trip_cnt=0, state=IDLE, all internal counters 0.
- wd_enable equals enable while in IDLE, and is 0 in every other state.
- IDLE: an accepted trip is wd_trip=1 with enable=1. An accepted trip or sw_rst_req moves the block to ASSERT on the next edge, so rx_rst is high 1 cycle after the request. On entry, the length counter is loaded with max(rst_len,1).
- ASSERT: rx_rst=1 for exactly max(rst_len,1) cycles. Then:
  - if holdoff_len != 0, go to HOLDOFF and load the holdoff counter;
  - otherwise go to IDLE.
  - wd_trip and sw_rst_req are ignored in ASSERT.
- HOLDOFF: rx_rst=0 for holdoff_len cycles, then IDLE. wd_trip is ignored and not counted. sw_rst_req re-enters ASSERT next cycle with the counter reloaded.
- Storm detection (only when storm_th != 0):
  - An accepted trip in IDLE while the window counter is 0 starts the window with storm_window cycles and sets the storm count to 1.
  - Further accepted trips inside the window increment the storm count.
  - When the window expires, the storm count clears.
  - If an accepted trip would bring the storm count to storm_th, the block enters LOCKOUT instead of ASSERT, with rx_rst=0. storm_th=1 therefore locks out on the first trip.
- LOCKOUT: rx_rst=0 and wd_enable=0. Exits to IDLE on cnt_clr=1 or enable=0. On exit, the storm count and window are cleared. sw_rst_req is ignored.
- trip_cnt increments by 1 on each accepted trip, including the trip that causes lockout. It saturates at all-ones.
  - cnt_clr clears it next cycle.
  - If cnt_clr and a trip occur in the same cycle, clear wins and the result is 0.
- sw_rst_req does not touch trip_cnt or the storm count.
- sw_rst_req and wd_trip together in IDLE: a single ASSERT; the trip is still counted and storm-checked, and lockout wins over ASSERT.
- enable=0 in any state forces IDLE next cycle with rx_rst=0. It clears the storm count, window and length counters; trip_cnt is kept. enable=0 has priority over all requests.
- Async reset asserted mid-ASSERT: rx_rst drops immediately (combinationally from rstn). Release is synchronous-safe; the first evaluation is at the first edge after deassertion.
- rst_len and holdoff_len are sampled only at counter load. Changing them mid-phase has no effect on the current phase.

Decomposition:
- Shared package: state encoding constants (S_IDLE=2'd0, S_ASSERT=2'd1, S_HOLDOFF=2'd2, S_LOCKOUT=2'd3) and default widths, reused by the status register block.
- One natural sub-module: storm_detector, holding the window counter and storm count. Its interface is trip_in, clear, storm_th, storm_window → storm_hit (combinational on the current trip).
- The FSM and the length/holdoff counters stay in the top module.

Test Plan:
- Basic trip: enable=1, rst_len=4, holdoff_len=10, single wd_trip pulse at cycle 0 → rx_rst high on cycles 1–4; busy high on 1–14; wd_enable=0 on 1–14; trip_cnt=1; state back to IDLE at cycle 15.
- Blanking: same setup with wd_trip held high for 20 cycles → exactly one rx_rst pulse, since trips in HOLDOFF are ignored; a second ASSERT starts at cycle 16 if wd_trip is still high; trip_cnt=2.
- Zero lengths: rst_len=0, holdoff_len=0, one trip → rx_rst high for exactly 1 cycle, then IDLE; busy high for 1 cycle.
- Storm: storm_th=3, storm_window=100, rst_len=2, holdoff_len=5, trips at cycles 0, 20, 40 → two resets, then LOCKOUT at cycle 41 with lockout=1, rx_rst=0, trip_cnt=3; cnt_clr pulse → IDLE and trip_cnt=0. With trips spaced 150 cycles apart instead, lockout never asserts.
- Priority and abort: sw_rst_req during HOLDOFF → ASSERT reload, trip_cnt unchanged. enable=0 mid-ASSERT → rx_rst=0 next cycle and state=IDLE. rstn asserted mid-ASSERT → rx_rst=0 immediately.
- Saturation and clear: preload trip_cnt to 0xFFFF with storm detection off, then one trip → stays 0xFFFF. cnt_clr together with a trip → 0.
